// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : md_sequencer
//  Description : Multiply/divide sequencer owning the architectural HI/LO
//                registers. Multiplies complete after MUL_CYCLES busy cycles,
//                divides run a 32-step restoring divider plus one sign-fixup
//                cycle (33 busy cycles total). MTHI/MTLO write in one edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_sequencer #(
    parameter int MUL_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        cancel,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_MUL  = 2'd1;
    localparam logic [1:0] c_S_DIV  = 2'd2;
    localparam logic [1:0] c_S_FIX  = 2'd3;

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    localparam logic [5:0] c_MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] c_DIV_LOAD = 6'd32;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [5:0]  r_cnt;
    logic [63:0] r_prod;
    logic [31:0] r_quo;
    logic [32:0] r_rem;
    logic [32:0] r_dvsr;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Issue qualification and operation decode
    logic        w_issue;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_signed;

    assign w_issue  = (r_state == c_S_IDLE) && start && !cancel;
    assign w_is_mul = (op == c_OP_MULT) || (op == c_OP_MULTU);
    assign w_is_div = (op == c_OP_DIV)  || (op == c_OP_DIVU);
    assign w_signed = (op == c_OP_MULT) || (op == c_OP_DIV);

    // Multiply: extend to 64 bits (sign or zero) so a truncated 64-bit
    // product is correct for both signed and unsigned forms.
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;

    assign w_ext_a = {{32{w_signed & src_a[31]}}, src_a};
    assign w_ext_b = {{32{w_signed & src_b[31]}}, src_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Divide operand magnitudes; |0x80000000| is 0x80000000 as unsigned.
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [32:0] w_mag_b;

    assign w_neg_a = w_signed & src_a[31];
    assign w_neg_b = w_signed & src_b[31];
    assign w_mag_a = w_neg_a ? (32'd0 - src_a) : src_a;
    assign w_mag_b = {1'b0, (w_neg_b ? (32'd0 - src_b) : src_b)};

    // One restoring step: shift remainder:quotient, trial-subtract divisor.
    logic [33:0] w_sh;
    logic        w_ge;
    logic [32:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;

    assign w_sh      = {r_rem, r_quo[31]};
    assign w_ge      = (w_sh >= {1'b0, r_dvsr});
    assign w_rem_nxt = w_ge ? 33'(w_sh - {1'b0, r_dvsr}) : w_sh[32:0];
    assign w_quo_nxt = {r_quo[30:0], w_ge};

    // Sign fixup applied in the final divide cycle
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_q_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
    assign w_r_fix = r_neg_r ? (32'd0 - r_rem[31:0]) : r_rem[31:0];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_issue && w_is_mul) begin
                    w_state_nxt = c_S_MUL;
                end else if (w_issue && w_is_div) begin
                    w_state_nxt = c_S_DIV;
                end
            end
            c_S_MUL: begin
                if (r_cnt == 6'd0) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_DIV: begin
                if (r_cnt == 6'd1) begin
                    w_state_nxt = c_S_FIX;
                end
            end
            c_S_FIX: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, counter, divider steps and HI/LO commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= 6'd0;
            r_prod  <= 64'd0;
            r_quo   <= 32'd0;
            r_rem   <= 33'd0;
            r_dvsr  <= 33'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_issue) begin
                        if (w_is_mul) begin
                            r_prod <= w_prod;
                            r_cnt  <= c_MUL_LOAD;
                        end else if (w_is_div) begin
                            r_quo   <= w_mag_a;
                            r_dvsr  <= w_mag_b;
                            r_rem   <= 33'd0;
                            r_neg_q <= w_neg_a ^ w_neg_b;
                            r_neg_r <= w_neg_a;
                            r_dz    <= (src_b == 32'd0);
                            r_cnt   <= c_DIV_LOAD;
                        end else if (op == c_OP_MTHI) begin
                            r_hi <= src_a;
                        end else if (op == c_OP_MTLO) begin
                            r_lo <= src_a;
                        end
                    end
                end
                c_S_MUL: begin
                    if (r_cnt == 6'd0) begin
                        r_hi   <= r_prod[63:32];
                        r_lo   <= r_prod[31:0];
                        r_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                c_S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - 6'd1;
                end
                c_S_FIX: begin
                    // A zero divisor still burns the full window but leaves HI/LO alone
                    if (!r_dz) begin
                        r_lo <= w_q_fix;
                        r_hi <= w_r_fix;
                    end
                    r_done <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = (r_state != c_S_IDLE);
    assign stall = busy || (start && w_is_mul) || (start && w_is_div);
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 5, busy cycles for MULT/MULTU; legal range 2..15.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset.
REQ-004 Port start  input  1  E-stage request to issue an MD operation this cycle.
REQ-005 Port op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
REQ-006 Port cancel  input  1  exception flush of the E stage; qualifies start only.
REQ-007 Port src_a  input  32  rs operand: dividend, multiplicand, or MTHI/MTLO data.
REQ-008 Port src_b  input  32  rt operand: divisor or multiplier.
REQ-009 Port busy  output  1  high while an operation is in flight (state != IDLE).
REQ-010 Port stall  output  1  combinational; busy OR (start AND op in {MULT, MULTU, DIV, DIVU}).
REQ-011 Port done  output  1  one-cycle pulse in the cycle after HI/LO commit.
REQ-012 Port hi  output  32  architectural HI register.
REQ-013 Port lo  output  32  architectural LO register.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, FIX.
REQ-015 An issue SHALL occur only on an edge where state==IDLE, start==1 and cancel==0; otherwise start is ignored with no side effect.
REQ-016 MTHI/MTLO issue SHALL write src_a into hi/lo at that edge; state stays IDLE; busy stays 0; done stays 0.
REQ-017 MULT/MULTU issue SHALL register the 64-bit signed/unsigned product of src_a and src_b, load the counter with MUL_CYCLES-1, and enter MUL.
REQ-018 In MUL the counter SHALL decrement each cycle; on the edge where it equals 0, {hi,lo} SHALL take the product and the state SHALL return to IDLE.
REQ-019 Busy SHALL be high for exactly MUL_CYCLES cycles after a multiply issue.
REQ-020 DIV/DIVU issue SHALL latch magnitudes of src_a and src_b (|x| for DIV; raw for DIVU), the operand signs, a zero-divisor flag, remainder=0, and counter=32, then enter DIV.
REQ-021 Each DIV cycle SHALL perform one restoring step (shift remainder:quotient left 1, trial-subtract divisor, keep if non-negative, set quotient bit) and decrement the counter; after the 32nd step the state SHALL go to FIX.
REQ-022 FIX SHALL negate the quotient if the signs differ (DIV only), give the remainder the sign of the dividend (DIV only), write LO=quotient and HI=remainder, and return to IDLE; busy SHALL be high for exactly 33 cycles.
REQ-023 Divisor zero: the full 33-cycle busy window SHALL still elapse; in FIX, hi and lo SHALL be left unchanged; done SHALL still pulse.
REQ-024 Magnitude arithmetic SHALL be 33 bits wide so that 0x80000000 is handled; DIV 0x80000000/0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-025 cancel during MUL/DIV/FIX SHALL NOT affect the in-flight operation.
REQ-026 hi/lo SHALL change only on MTHI/MTLO issue, MUL completion, FIX, or reset.

Reset
REQ-027 Asserting rst low SHALL immediately, regardless of clk, force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and discard any partial result.
REQ-028 After rst is released, the first issue SHALL be accepted on the first rising edge.

Verification
REQ-029 MULT src_a=0xFFFFFFFE, src_b=3 -> busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 DIVU 100/7 -> busy 33 cycles, lo=14, hi=2; DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 DIV by 0 with hi=0x11, lo=0x22 -> busy 33 cycles, done pulses, hi=0x11, lo=0x22 unchanged.
REQ-032 start=1, op=MULT, cancel=1 -> stall=1 that cycle, busy stays 0, hi/lo unchanged; MTHI 0x5 with start while busy -> ignored, hi unchanged.
REQ-033 rst low in DIV step 10 -> busy=0, hi=lo=0 before the next clk edge; a new DIVU issued after release completes normally.
